// File: rtl/pio_poll_pkg.sv
// Shared types and helpers for the done-PIO poller: FSM state encoding,
// PIO geometry constants and the masked compare used on every captured read.
package pio_poll_pkg;

    localparam int         PIO_DATA_W       = 7;
    localparam logic [1:0] PIO_ADDR_DEFAULT = 2'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        GAP     = 2'd3
    } poll_state_t;

    // Callers zero-extend into 32 bits so the helper works for any DATA_W up to 31.
    function automatic logic masked_eq(
        input logic [31:0] data,
        input logic [31:0] match,
        input logic [31:0] mask
    );
        return ((data & mask) == (match & mask));
    endfunction

endpackage

// File: rtl/poll_gap_timer.sv
// Loadable down-counter that times the idle gap between two PIO reads.
// o_expire is high on the cycle the count reads 1, i.e. the last idle cycle.
module poll_gap_timer #(
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [GAP_W-1:0] i_load_val,
    input  logic             i_count_en,
    output logic             o_expire
);

    logic [GAP_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_count_en && (r_count != '0)) begin
            r_count <= r_count - GAP_W'(1);
        end
    end

    assign o_expire = (r_count == GAP_W'(1));

endmodule

// File: rtl/pio_done_poller.sv
// Avalon-MM read initiator that polls a done PIO until (data & mask) == (match & mask).
// Defining POLL_TIMEOUT_EN builds a poll counter that pulses timeout after MAX_POLLS reads.
module pio_done_poller
    import pio_poll_pkg::*;
#(
    parameter int         DATA_W    = PIO_DATA_W,
    parameter logic [1:0] PIO_ADDR  = PIO_ADDR_DEFAULT,
    parameter int         GAP_W     = 8,
    parameter int         POLL_GAP  = 4,
    parameter int         MAX_POLLS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] match,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] status,
    output logic              timeout,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output poll_state_t       dbg_state
);

    poll_state_t       r_state;
    poll_state_t       w_state_next;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_match;
    logic [DATA_W-1:0] r_status;
    logic              r_done;
    logic              r_timeout;
    logic              w_hit;
    logic              w_capture_ok;
    logic              w_poll_last;
    logic              w_gap_load;
    logic              w_gap_count_en;
    logic              w_gap_expire;
    logic              w_unused_hi;

    // The slave's readdata is registered, so in CAPTURE it holds the ISSUE read.
    assign w_hit        = masked_eq(32'(avm_readdata[DATA_W-1:0]), 32'(r_match), 32'(r_mask));
    assign w_capture_ok = (r_state == CAPTURE) && !abort;
    assign w_unused_hi  = ^avm_readdata[31:DATA_W];

`ifdef POLL_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_POLLS + 1);

    logic [CNT_W-1:0] r_poll_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_poll_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_poll_cnt <= '0;
        end else if (w_capture_ok && !w_hit) begin
            r_poll_cnt <= r_poll_cnt + CNT_W'(1);
        end
    end

    // A mismatch now would bring the count to MAX_POLLS.
    assign w_poll_last = (r_poll_cnt == CNT_W'(MAX_POLLS - 1));
`else
    logic w_unused_cfg;

    assign w_poll_last  = 1'b0;
    assign w_unused_cfg = (MAX_POLLS > 0);
`endif

    poll_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_gap_load),
        .i_load_val (GAP_W'(POLL_GAP)),
        .i_count_en (w_gap_count_en),
        .o_expire   (w_gap_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_gap_load     = 1'b0;
        w_gap_count_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_state_next = abort ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                if (abort || w_hit || w_poll_last) begin
                    w_state_next = IDLE;
                end else if (POLL_GAP == 0) begin
                    w_state_next = ISSUE;
                end else begin
                    w_gap_load   = 1'b1;
                    w_state_next = GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_gap_count_en = 1'b1;
                    if (w_gap_expire) begin
                        w_state_next = ISSUE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Abort in CAPTURE suppresses both the result pulse and the status update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask    <= '0;
            r_match   <= '0;
            r_status  <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= w_capture_ok && w_hit;
            r_timeout <= w_capture_ok && !w_hit && w_poll_last;
            if ((r_state == IDLE) && start) begin
                r_mask  <= mask;
                r_match <= match;
            end
            if (w_capture_ok) begin
                r_status <= avm_readdata[DATA_W-1:0];
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign avm_read    = (r_state == ISSUE);
    assign avm_address = PIO_ADDR;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign status      = r_status;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pio_done_poller.sv
// Directed bench for pio_done_poller with a registered, latency-1 PIO slave model.
// Checks cycle timing of reads, done/timeout pulses, abort, reset and start filtering.
module tb_pio_done_poller;
    import pio_poll_pkg::*;

    localparam int TB_POLL_GAP  = 4;
    localparam int TB_MAX_POLLS = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [6:0]  mask;
    logic [6:0]  match;
    logic        busy;
    logic        done;
    logic [6:0]  status;
    logic        timeout;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    poll_state_t dbg_state;

    logic [6:0]  pio_val;
    logic [24:0] pio_hi;

    int n_checks;
    int n_pass;
    int n_reads;
    int n_dones;
    int n_touts;
    int rd0;
    int dn0;
    int to0;

    pio_done_poller #(
        .DATA_W    (7),
        .PIO_ADDR  (2'd0),
        .GAP_W     (8),
        .POLL_GAP  (TB_POLL_GAP),
        .MAX_POLLS (TB_MAX_POLLS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mask         (mask),
        .match        (match),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .timeout      (timeout),
        .avm_address  (avm_address),
        .avm_read     (avm_read),
        .avm_readdata (avm_readdata),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // PIO slave: registered readdata, latency 1, upper bits carry junk
    initial avm_readdata = '0;
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= {pio_hi, pio_val};
    end

    always @(negedge clk) begin
        if (avm_read) n_reads++;
        if (done)     n_dones++;
        if (timeout)  n_touts++;
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        rd0 = n_reads;
        dn0 = n_dones;
        to0 = n_touts;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        n_reads = 0; n_dones = 0; n_touts = 0;
        rd0 = 0; dn0 = 0; to0 = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        mask = '0; match = '0; pio_val = '0; pio_hi = 25'h1ABCDEF;
        repeat (3) step();
        reset = 1'b0;
        step();

        // reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_read", avm_read, 0);
        check("rst_status", status, 0);
        check("rst_address", avm_address, 0);

        // first-read match: read in 1, compare in 2, done in 3
        pio_val = 7'h01; mask = 7'h01; match = 7'h01; start = 1'b1; snap();
        step(); start = 1'b0;
        check("t1_c1_read", avm_read, 1);
        check("t1_c1_busy", busy, 1);
        check("t1_c1_done", done, 0);
        step();
        check("t1_c2_read", avm_read, 0);
        check("t1_c2_busy", busy, 1);
        check("t1_c2_done", done, 0);
        step();
        check("t1_c3_done", done, 1);
        check("t1_c3_busy", busy, 0);
        check("t1_c3_status", status, 7'h01);
        check("t1_c3_read", avm_read, 0);
        step();
        check("t1_c4_done", done, 0);
        check("t1_reads", n_reads - rd0, 1);
        check("t1_dones", n_dones - dn0, 1);

        // period 6 polling; PIO set during third gap; match on the final allowed read
        pio_val = 7'h00; mask = 7'h40; match = 7'h40; start = 1'b1; snap();
        for (int c = 1; c <= 22; c++) begin
            step(); start = 1'b0;
            if (c == 16) pio_val = 7'h40;
            check("t2_read", avm_read, ((c % 6) == 1) && (c <= 19));
            check("t2_done", done, c == 21);
            check("t2_busy", busy, c <= 20);
            check("t2_timeout", timeout, 0);
            if (c == 9)  check("t2_status_hold", status, 7'h00);
            if (c == 21) check("t2_status", status, 7'h40);
        end
        check("t2_reads", n_reads - rd0, 4);
        check("t2_dones", n_dones - dn0, 1);

        // never-matching poll, abort mid-GAP
        pio_val = 7'h7F; mask = 7'h0F; match = 7'h0A; start = 1'b1; snap();
        for (int c = 1; c <= 14; c++) begin
            step(); start = 1'b0;
            if (c <= 10) check("t3_busy_on", busy, 1);
            if (c >= 11) check("t3_busy_off", busy, 0);
            if (c >= 11) check("t3_read_off", avm_read, 0);
            check("t3_done", done, 0);
            if (c == 11) check("t3_status", status, 7'h7F);
            if (c == 10) abort = 1'b1;
            if (c == 11) abort = 1'b0;
        end
        check("t3_reads", n_reads - rd0, 2);
        check("t3_dones", n_dones - dn0, 0);
        check("t3_touts", n_touts - to0, 0);

        // poll exhaustion
        pio_val = 7'h00; mask = 7'h7F; match = 7'h01; start = 1'b1; snap();
        for (int c = 1; c <= 26; c++) begin
            step(); start = 1'b0;
            check("t4_done", done, 0);
`ifdef POLL_TIMEOUT_EN
            check("t4_read", avm_read, ((c % 6) == 1) && (c <= 19));
            check("t4_timeout", timeout, c == 21);
            check("t4_busy", busy, c <= 20);
`else
            check("t4_read", avm_read, (c % 6) == 1);
            check("t4_timeout", timeout, 0);
            check("t4_busy", busy, 1);
`endif
            if (c == 26) abort = 1'b1;
        end
        step(); abort = 1'b0;
        check("t4_busy_end", busy, 0);
`ifdef POLL_TIMEOUT_EN
        check("t4_reads", n_reads - rd0, 4);
        check("t4_touts", n_touts - to0, 1);
`else
        check("t4_reads", n_reads - rd0, 5);
        check("t4_touts", n_touts - to0, 0);
`endif

        // reset during CAPTURE of a matching read
        pio_val = 7'h05; mask = 7'h07; match = 7'h05; start = 1'b1; snap();
        step(); start = 1'b0;
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_read", avm_read, 0);
        check("t5_timeout", timeout, 0);
        check("t5_status", status, 0);
        step();
        step();
        check("t5_no_done", n_dones - dn0, 0);
        start = 1'b1;
        step(); start = 1'b0;
        check("t5_restart_read", avm_read, 1);
        step();
        step();
        check("t5_restart_done", done, 1);
        check("t5_restart_status", status, 7'h05);

        // mask=0 always matches; starts while busy are ignored
        pio_val = 7'h00; mask = 7'h00; match = 7'h33; start = 1'b1; snap();
        step(); mask = 7'h7F; match = 7'h7F;
        check("t6_c1_read", avm_read, 1);
        step(); start = 1'b0;
        check("t6_c2_read", avm_read, 0);
        step();
        check("t6_c3_done", done, 1);
        check("t6_c3_status", status, 7'h00);
        step();
        check("t6_c4_done", done, 0);
        check("t6_c4_busy", busy, 0);
        step();
        check("t6_reads", n_reads - rd0, 1);
        check("t6_dones", n_dones - dn0, 1);

        // start with abort in IDLE is accepted
        pio_val = 7'h01; mask = 7'h01; match = 7'h01; start = 1'b1; abort = 1'b1; snap();
        step(); start = 1'b0; abort = 1'b0;
        check("t7_busy", busy, 1);
        check("t7_read", avm_read, 1);
        step();
        step();
        check("t7_done", done, 1);

        // abort wins over a match in CAPTURE, status keeps its old value
        pio_val = 7'h03; start = 1'b1; snap();
        step(); start = 1'b0;
        step(); abort = 1'b1;
        step(); abort = 1'b0;
        check("t8_done", done, 0);
        check("t8_busy", busy, 0);
        check("t8_status", status, 7'h01);
        step();
        check("t8_dones", n_dones - dn0, 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
